// File: rtl/jtag_mem_loader.sv
// Serial word loader: streams DEPTH*NBANKS words from a JTAG-style port into banked memory.
// Optional readback path enabled by defining LOADER_READBACK_EN.
module jtag_mem_loader #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 512,
    parameter  int NBANKS = 2,
    localparam int AW     = $clog2(DEPTH),
    localparam int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Jen,
    input  logic             Jmode,
    input  logic [WIDTH-1:0] Jin,
    output logic [WIDTH-1:0] Jout,
    output logic             Jvalid,
    output logic             mem_we,
    output logic [BW-1:0]    mem_bank,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
`ifdef LOADER_READBACK_EN
        READ,
`endif
        DONE
    } state_t;

    state_t          state;
    logic [BW-1:0]   bank;
    logic [AW-1:0]   addr;
    logic            is_read;
    logic            last_word;

`ifdef LOADER_READBACK_EN
    logic            rd_req;
    logic            rd_valid;
`endif

    always_comb begin
        is_read = 1'b0;
`ifdef LOADER_READBACK_EN
        is_read = (state == READ) || ((state == IDLE) && Jmode);
`endif
        last_word = (bank == BW'(NBANKS - 1)) && (addr == '0);
    end

    // IDLE, LOAD and READ share the word-moving path; IDLE picks the direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bank      <= '0;
            addr      <= '1;
            mem_we    <= 1'b0;
            mem_bank  <= '0;
            mem_addr  <= '1;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
`ifdef LOADER_READBACK_EN
            rd_req    <= 1'b0;
            rd_valid  <= 1'b0;
`endif
        end else begin
            mem_we    <= 1'b0;
            mem_wdata <= Jin;
`ifdef LOADER_READBACK_EN
            rd_req    <= 1'b0;
            rd_valid  <= rd_req;
`endif
            case (state)
                DONE: begin
                    if (Jen) begin
                        ovf <= 1'b1;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    if (Jen) begin
                        mem_bank <= bank;
                        mem_addr <= addr;
                        if (is_read) begin
`ifdef LOADER_READBACK_EN
                            rd_req <= 1'b1;
`endif
                        end else begin
                            mem_we <= 1'b1;
                        end
                        if (last_word) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            bank  <= '0;
                            addr  <= '1;
                        end else begin
`ifdef LOADER_READBACK_EN
                            state <= is_read ? READ : LOAD;
`else
                            state <= LOAD;
`endif
                            busy  <= 1'b1;
                            if (addr == '0) begin
                                bank <= bank + BW'(1);
                                addr <= '1;
                            end else begin
                                addr <= addr - AW'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef LOADER_READBACK_EN
    // Synchronous memory returns data the cycle after the request is registered.
    assign Jvalid = rd_valid;
    assign Jout   = rd_valid ? mem_rdata : '0;
`else
    logic unused_inputs;
    assign unused_inputs = ^{Jmode, mem_rdata, is_read};
    assign Jvalid = 1'b0;
    assign Jout   = '0;
`endif

endmodule
